// File: rtl/core_pkg.sv
// Shared definitions for the boot bridge: loader FSM states and boot constants.
// BOOT_CHECKSUM_EN adds the trailing checksum-byte state.
package core_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
        ST_RUN,
`ifdef BOOT_CHECKSUM_EN
        ST_ERR,
        ST_CSUM
`else
        ST_ERR
`endif
    } boot_state_e;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;
    localparam int unsigned BOOT_HDR_BYTES    = 4;

endpackage

// File: rtl/boot_loader_fsm.sv
// Byte-stream boot loader: assembles a little-endian header and payload words and writes imem.
// BOOT_CHECKSUM_EN: verify a trailing mod-256 payload checksum byte before releasing the core.
module boot_loader_fsm
    import core_pkg::*;
#(
    parameter int unsigned IMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               core_rstn,
    output logic               boot_done,
    output logic               boot_err,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_din
);

    localparam logic [32:0] IMEM_DEPTH = 33'd1 << IMEM_AW;
    localparam logic [1:0]  LAST_BYTE  = 2'(BOOT_HDR_BYTES - 1);

    boot_state_e        state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        shift_q, shift_d;
    logic [IMEM_AW:0]   count_q, count_d;
    logic [IMEM_AW:0]   widx_q, widx_d;
    logic               we_q, we_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [31:0]        din_q, din_d;
    logic               rx_ready_q, rx_ready_d;
    logic               core_rstn_q;
    logic               accept;
    logic [31:0]        word;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
    localparam boot_state_e ST_AFTER_LOAD = ST_CSUM;
`else
    localparam boot_state_e ST_AFTER_LOAD = ST_RUN;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        count_d    = count_q;
        widx_d     = widx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        accept = rx_valid & rx_ready_q;
        word   = {rx_data, shift_q};

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = word[31:8];
        end

        case (state_q)
            ST_HDR: begin
                if (accept && byte_cnt_q == LAST_BYTE) begin
                    widx_d = '0;
                    if (word == '0) begin
                        state_d = ST_AFTER_LOAD;
                    end else if ({1'b0, word} > IMEM_DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        count_d = word[IMEM_AW:0];
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q + rx_data;
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        we_d   = 1'b1;
                        din_d  = word;
                        addr_d = widx_q[IMEM_AW-1:0];
                        widx_d = widx_q + (IMEM_AW + 1)'(1);
                        if (widx_d == count_q) begin
                            state_d = ST_AFTER_LOAD;
                        end
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
                end
            end
`endif
            default: ;
        endcase

        // Registered from next state so rx_ready is low in reset and drops on the final byte's edge.
        rx_ready_d = (state_d == ST_HDR) || (state_d == ST_LOAD)
`ifdef BOOT_CHECKSUM_EN
                     || (state_d == ST_CSUM)
`endif
                     ;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_HDR;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            widx_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rx_ready_q  <= 1'b0;
            core_rstn_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            widx_q      <= widx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rx_ready_q  <= rx_ready_d;
            core_rstn_q <= (state_q == ST_RUN);
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign core_rstn = core_rstn_q;
    assign boot_done = (state_q == ST_RUN);
    assign boot_err  = (state_q == ST_ERR);
    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_din  = din_q;

endmodule

// File: rtl/core_boot_bridge.sv
// Core wrapper: boot loader for imem plus data routing between dmem and an MMIO LED register.
// BOOT_CHECKSUM_EN (see boot_loader_fsm) enables the trailing boot checksum byte.
module core_boot_bridge
    import core_pkg::*;
#(
    parameter int unsigned IMEM_AW   = 14,
    parameter int unsigned NUM_LED   = 8,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               core_rstn,
    output logic               boot_done,
    output logic               boot_err,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_din,
    input  logic [31:0]        core_addr,
    input  logic [31:0]        core_din,
    input  logic               core_we,
    output logic [31:0]        core_dout,
    output logic [31:0]        dmem_addr,
    output logic [31:0]        dmem_din,
    output logic               dmem_we,
    input  logic [31:0]        dmem_dout,
    output logic [NUM_LED-1:0] led
);

    boot_loader_fsm #(
        .IMEM_AW(IMEM_AW)
    ) u_loader (
        .clk       (clk),
        .rstn      (rstn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .core_rstn (core_rstn),
        .boot_done (boot_done),
        .boot_err  (boot_err),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_din  (imem_din)
    );

    logic               is_mmio, is_led, led_wr;
    logic [NUM_LED-1:0] led_q, led_d;
    logic [NUM_LED-1:0] led_rd_q, led_rd_d;
    logic               mmio_q;
    logic [31:0]        led_ext;

    always_comb begin
        is_mmio  = (core_addr >= MMIO_BASE);
        is_led   = (core_addr == MMIO_BASE);
        led_wr   = core_rstn & core_we & is_led;
        led_d    = led_wr ? core_din[NUM_LED-1:0] : led_q;
        // Capture the post-write value so a read right after a store sees the new LED state.
        led_rd_d = is_led ? led_d : '0;
        dmem_we  = core_rstn & core_we & ~is_mmio;
        led_ext  = '0;
        led_ext[NUM_LED-1:0] = led_rd_q;
        core_dout = mmio_q ? led_ext : dmem_dout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q    <= '0;
            led_rd_q <= '0;
            mmio_q   <= 1'b0;
        end else begin
            led_q    <= led_d;
            led_rd_q <= led_rd_d;
            mmio_q   <= is_mmio;
        end
    end

    assign dmem_addr = core_addr;
    assign dmem_din  = core_din;
    assign led       = led_q;

endmodule

// File: tb/tb_core_boot_bridge.sv
// Self-checking bench for core_boot_bridge: boot sequences, imem write scoreboard, MMIO routing table.
// Define BOOT_CHECKSUM_EN consistently with the RTL build to exercise the checksum byte.
module tb_core_boot_bridge;

    localparam int unsigned AW   = 14;
    localparam int unsigned NLED = 8;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [7:0]      rx_data = '0;
    logic            rx_valid = 1'b0;
    logic            rx_ready, core_rstn, boot_done, boot_err, imem_we;
    logic [AW-1:0]   imem_addr;
    logic [31:0]     imem_din;
    logic [31:0]     core_addr = '0, core_din = '0, dmem_dout = '0;
    logic            core_we = 1'b0;
    logic [31:0]     core_dout, dmem_addr, dmem_din;
    logic            dmem_we;
    logic [NLED-1:0] led;

    core_boot_bridge #(
        .IMEM_AW  (AW),
        .NUM_LED  (NLED),
        .MMIO_BASE(BASE)
    ) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .core_rstn(core_rstn), .boot_done(boot_done), .boot_err(boot_err),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
        .core_addr(core_addr), .core_din(core_din), .core_we(core_we), .core_dout(core_dout),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_we(dmem_we), .dmem_dout(dmem_dout),
        .led(led)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] rdata;
        logic        exp_we;
        logic [7:0]  exp_led;
        logic        chk;
        logic [31:0] exp_dout;
    } vec_t;
    vec_t tbl[11];
    logic [32:0] dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // imem write scoreboard
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL imem_unexpected: got addr %h data %h expected no write", imem_addr, imem_din);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("imem_addr", 32'(imem_addr), 32'(e.addr));
                chk("imem_din", imem_din, e.data);
            end
        end
    end

    function automatic logic [7:0] bsum(input logic [31:0] w);
        return w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL rx_ready_timeout: got %b expected 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_core_rstn"}, 32'(core_rstn), 32'd0);
        chk({tag, "_boot_done"}, 32'(boot_done), 32'd0);
        chk({tag, "_boot_err"}, 32'(boot_err), 32'd0);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_imem_din"}, imem_din, 32'd0);
        chk({tag, "_led"}, 32'(led), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rstn     = 1'b0;
        rx_valid = 1'b0;
        core_we  = 1'b0;
        #1;
        check_reset_vals(tag);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_run_entry(input string tag);
        chk({tag, "_boot_done"}, 32'(boot_done), 32'd1);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_core_rstn_lag"}, 32'(core_rstn), 32'd0);
        @(negedge clk);
        chk({tag, "_core_rstn"}, 32'(core_rstn), 32'd1);
    endtask

    initial begin
        logic [31:0] w0, w1;
        logic [32:0] e;

        tbl[0]  = '{1'b1, BASE,          32'h0000_00A5, 32'h0,         1'b0, 8'hA5, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, BASE,          32'h0,         32'h0,         1'b0, 8'hA5, 1'b1, 32'h0000_00A5};
        tbl[2]  = '{1'b1, 32'h100,       32'hDEAD_BEEF, 32'h0,         1'b1, 8'hA5, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h100,       32'h0,         32'h1234_5678, 1'b0, 8'hA5, 1'b1, 32'h1234_5678};
        tbl[4]  = '{1'b0, BASE + 32'd4,  32'h0,         32'hFFFF_FFFF, 1'b0, 8'hA5, 1'b1, 32'h0};
        tbl[5]  = '{1'b1, BASE + 32'd4,  32'h0000_00FF, 32'h0,         1'b0, 8'hA5, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, BASE,          32'h0,         32'hAAAA_AAAA, 1'b0, 8'hA5, 1'b1, 32'h0000_00A5};
        tbl[7]  = '{1'b1, BASE,          32'hFFFF_FF3C, 32'h0,         1'b0, 8'h3C, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, BASE,          32'h0,         32'h0,         1'b0, 8'h3C, 1'b1, 32'h0000_003C};
        tbl[9]  = '{1'b1, BASE - 32'd4,  32'h0000_0001, 32'h0,         1'b1, 8'h3C, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0000_0055, 1'b0, 8'h3C, 1'b1, 32'h0};

        // Reset values, then writes blocked while the core is held in reset
        #2;
        check_reset_vals("rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        core_we = 1'b1; core_addr = BASE; core_din = 32'hFF;
        #1 chk("blocked_led_dmem_we", 32'(dmem_we), 32'd0);
        core_addr = 32'h100;
        #1 chk("blocked_dmem_we", 32'(dmem_we), 32'd0);
        core_addr = BASE;
        @(negedge clk);
        chk("blocked_led", 32'(led), 32'd0);
        core_we = 1'b0;

        // Two-word boot with idle gaps
        w0 = 32'h0000_0013;
        w1 = 32'h0010_0093;
        send_word(32'd2, 2);
        wq.push_back('{14'd0, w0});
        send_word(w0, 1);
        wq.push_back('{14'd1, w1});
        send_word(w1, 3);
`ifdef BOOT_CHECKSUM_EN
        send_byte(bsum(w0) + bsum(w1), 1);
`endif
        check_run_entry("boot2");
        repeat (3) @(negedge clk);
        chk("run_rx_ready", 32'(rx_ready), 32'd0);

        // Data routing table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            core_we   = tbl[i].we;
            core_addr = tbl[i].addr;
            core_din  = tbl[i].din;
            dmem_dout = (i > 0) ? tbl[i-1].rdata : 32'h0;
            #1;
            chk($sformatf("v%0d_dmem_we", i), 32'(dmem_we), 32'(tbl[i].exp_we));
            chk($sformatf("v%0d_dmem_addr", i), dmem_addr, tbl[i].addr);
            if (i > 0) begin
                e = dq.pop_front();
                if (e[32]) chk($sformatf("v%0d_core_dout", i - 1), core_dout, e[31:0]);
                chk($sformatf("v%0d_led", i - 1), 32'(led), 32'(tbl[i-1].exp_led));
            end
            dq.push_back({tbl[i].chk, tbl[i].exp_dout});
        end
        @(negedge clk);
        core_we   = 1'b0;
        dmem_dout = tbl[10].rdata;
        #1;
        e = dq.pop_front();
        if (e[32]) chk("v10_core_dout", core_dout, e[31:0]);
        chk("v10_led", 32'(led), 32'(tbl[10].exp_led));

        // Empty image
        do_reset("rst_n0");
        send_word(32'd0, 1);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        check_run_entry("n0");

        // Oversized image
        do_reset("rst_big");
        send_word(32'h0000_4001, 0);
        chk("big_boot_err", 32'(boot_err), 32'd1);
        chk("big_boot_done", 32'(boot_done), 32'd0);
        chk("big_rx_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("big_core_rstn", 32'(core_rstn), 32'd0);

        // Exactly full-depth header is accepted
        do_reset("rst_full");
        send_word(32'h0000_4000, 0);
        chk("full_boot_err", 32'(boot_err), 32'd0);
        chk("full_rx_ready", 32'(rx_ready), 32'd1);

        // Reset after 6 of 8 payload bytes, then complete re-boot
        do_reset("rst_mid0");
        send_word(32'd2, 0);
        wq.push_back('{14'd0, 32'h1111_2222});
        send_word(32'h1111_2222, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        do_reset("rst_mid");
        w0 = 32'hCAFE_F00D;
        w1 = 32'h0BAD_C0DE;
        send_word(32'd2, 1);
        wq.push_back('{14'd0, w0});
        send_word(w0, 0);
        wq.push_back('{14'd1, w1});
        send_word(w1, 0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(bsum(w0) + bsum(w1), 0);
`endif
        check_run_entry("reboot");

`ifdef BOOT_CHECKSUM_EN
        do_reset("rst_cs_ok");
        send_word(32'd1, 0);
        wq.push_back('{14'd0, 32'h0403_0201});
        send_word(32'h0403_0201, 0);
        send_byte(8'h0A, 0);
        check_run_entry("cs_ok");

        do_reset("rst_cs_bad");
        send_word(32'd1, 0);
        wq.push_back('{14'd0, 32'h0403_0201});
        send_word(32'h0403_0201, 0);
        send_byte(8'h0B, 0);
        chk("cs_bad_boot_err", 32'(boot_err), 32'd1);
        chk("cs_bad_boot_done", 32'(boot_done), 32'd0);
        @(negedge clk);
        chk("cs_bad_core_rstn", 32'(core_rstn), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("imem_queue_empty", 32'(wq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
